// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_pkg
// Purpose  : Shared types and default constants for the sync_ram block.
//            Holds the controller state encoding and the default geometry.
// Revision : 1.0 - initial release
// ============================================================================
package ram_pkg;

    localparam int c_data_w_dflt     = 16;
    localparam int c_addr_w_dflt     = 16;
    localparam int c_init_clear_dflt = 1;

    // CLEAR : post-reset zeroing sweep, one word per cycle
    // IDLE  : ready for any request
    // RESP  : a read response is being presented
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_array.sv
`default_nettype none
// ============================================================================
// Module   : ram_array
// Purpose  : Single-port storage, DATA_W x 2**ADDR_W, synchronous write and
//            synchronous (registered) read. The read register only updates
//            on a read access, so it holds its value while a response waits.
// Ports    : clk    - clock
//            en     - port access this cycle
//            we     - 1 = write, 0 = read (qualified by en)
//            addr   - word address
//            wdata  - write data
//            rdata  - registered read data
// Revision : 1.0 - initial release
// ============================================================================
module ram_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int c_depth = 2 ** ADDR_W;

    // Storage is deliberately not reset; the controller's clear sweep
    // provides the zero initialisation.
    logic [DATA_W-1:0] r_mem [c_depth];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                r_mem[addr] <= wdata;
            end else begin
                r_rdata <= r_mem[addr];
            end
        end
    end

    assign rdata = r_rdata;

endmodule : ram_array
`default_nettype wire

// File: rtl/sync_ram.sv
`default_nettype none
// ============================================================================
// Module   : sync_ram
// Purpose  : Request/response wrapper around a single-port synchronous RAM
//            with an optional post-reset clear sweep and read latency of 1.
// Ports    : clk, rst           - clock, asynchronous active-high reset
//            req_valid/req_ready - request handshake
//            req_rd, req_we      - read / write select (both high = illegal)
//            req_addr, req_wdata - address and write data
//            resp_valid/ready    - response handshake
//            resp_rdata          - read data
//            busy                - clear sweep in progress
//            err                 - one-cycle pulse on an illegal request
// Revision : 1.0 - initial release
// ============================================================================
module sync_ram
    import ram_pkg::*;
#(
    parameter int DATA_W     = c_data_w_dflt,
    parameter int ADDR_W     = c_addr_w_dflt,
    parameter int INIT_CLEAR = c_init_clear_dflt
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rd,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy,
    output logic              err
);

    localparam logic [ADDR_W-1:0] c_last_addr = {ADDR_W{1'b1}};
    localparam state_t            c_rst_state = (INIT_CLEAR != 0) ? CLEAR : IDLE;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_err;

    logic              w_accept;
    logic              w_req_err;
    logic              w_mem_en;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W-1:0] w_mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_rst_state;
            r_clr_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_req_err;
            if (r_state == CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        w_accept    = 1'b0;
        w_req_err   = 1'b0;
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = req_addr;
        w_mem_wdata = req_wdata;

        case (r_state)
            CLEAR: begin
                // The sweep owns the array port; requests are locked out.
                w_mem_en    = 1'b1;
                w_mem_we    = 1'b1;
                w_mem_addr  = r_clr_cnt;
                w_mem_wdata = '0;
                if (r_clr_cnt == c_last_addr) begin
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                req_ready = 1'b1;
            end
            RESP: begin
                // A new request may only enter while the current response
                // is being taken, which gives bubble-free back-to-back reads.
                req_ready = resp_ready;
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = c_rst_state;
            end
        endcase

        w_accept = req_valid && req_ready;
        if (w_accept) begin
            if (req_rd && !req_we) begin
                w_mem_en    = 1'b1;
                w_state_nxt = RESP;
            end else if (req_we && !req_rd) begin
                w_mem_en = 1'b1;
                w_mem_we = 1'b1;
            end else if (req_we && req_rd) begin
                w_req_err = 1'b1;
            end
        end
    end

    ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram_array (
        .clk   (clk),
        .en    (w_mem_en),
        .we    (w_mem_we),
        .addr  (w_mem_addr),
        .wdata (w_mem_wdata),
        .rdata (w_mem_rdata)
    );

    assign busy       = (r_state == CLEAR);
    assign resp_valid = (r_state == RESP);
    // Gate with the state so the output reads zero out of reset even though
    // the array's read register is never reset.
    assign resp_rdata = (r_state == RESP) ? w_mem_rdata : '0;
    assign err        = r_err;

endmodule : sync_ram
`default_nettype wire

// File: doc/sync_ram.md
SYNC_RAM -- requirements
Module: sync_ram

Interface
REQ-001 SHALL have parameter DATA_W, default 16: word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 16: address width in bits; depth DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter INIT_CLEAR, default 1: 1 = zero the whole array after reset; 0 = no clear sweep.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk, rst.
REQ-005 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  request accepted this cycle when req_valid is also high.
REQ-009 SHALL have port req_rd  input  1  request is a read.
REQ-010 SHALL have port req_we  input  1  request is a write.
REQ-011 SHALL have port req_addr  input  ADDR_W  word address.
REQ-012 SHALL have port req_wdata  input  DATA_W  write data.
REQ-013 SHALL have port resp_valid  output  1  read data valid.
REQ-014 SHALL have port resp_ready  input  1  consumer takes the response.
REQ-015 SHALL have port resp_rdata  output  DATA_W  read data.
REQ-016 SHALL have port busy  output  1  clear sweep in progress.
REQ-017 SHALL have port err  output  1  one-cycle pulse on an illegal request.

Function
REQ-018 SHALL implement FSM states CLEAR, IDLE and RESP.
REQ-019 SHALL leave CLEAR for IDLE after writing address DEPTH-1.
REQ-020 SHALL, in CLEAR, write zero to one address per cycle, counting from 0 up to DEPTH-1, and hold busy=1 and req_ready=0.
REQ-021 SHALL drive req_ready=1 in IDLE, and in RESP only when resp_ready=1; in RESP this pipelines back-to-back reads.
REQ-022 SHALL, on an accepted write (req_rd=0, req_we=1), store req_wdata at req_addr on that clock edge, produce no response, and stay in or return to IDLE.
REQ-023 SHALL, on an accepted read (req_rd=1, req_we=0), present mem[req_addr] on resp_rdata with resp_valid=1 in the next cycle (latency 1), entering RESP.
REQ-024 SHALL hold resp_valid and resp_rdata stable while resp_valid=1 and resp_ready=0.
REQ-025 SHALL, in RESP with resp_ready=1 and no new read accepted, clear resp_valid next cycle and return to IDLE.
REQ-026 SHALL, in RESP with resp_ready=1 and a new read accepted, keep resp_valid=1 and update resp_rdata next cycle, with no bubble.
REQ-027 SHALL make a read accepted the cycle after a write to the same address return the newly written data.
REQ-028 SHALL, when an accepted request has req_rd=1 and req_we=1, perform no memory access, produce no response, and pulse err high for exactly one cycle.
REQ-029 SHALL treat an accepted request with req_rd=0 and req_we=0 as a no-op with no err pulse.
REQ-030 SHALL ignore req_* inputs whenever req_ready=0.
REQ-031 SHALL take addresses modulo DEPTH; no out-of-range case exists.
REQ-032 SHALL, with INIT_CLEAR=0, leave reset directly in IDLE with memory contents undefined.

Reset
REQ-033 SHALL, on rst high, immediately force: state = CLEAR if INIT_CLEAR=1, else IDLE; clear counter = 0; resp_valid = 0; resp_rdata = 0; err = 0; busy = INIT_CLEAR.
REQ-034 SHALL, when rst is asserted during a clear sweep or a pending response, abort it, drop any pending response, and restart the clear sweep from address 0 after release.
REQ-035 SHALL NOT reset the storage array itself; only the clear sweep zeroes it.

Structure
REQ-036 SHALL place the FSM state enum type (CLEAR/IDLE/RESP) and default parameter constants in shared package ram_pkg.
REQ-037 SHALL isolate storage in sub-module ram_array: single-port array, DATA_W x DEPTH, with synchronous write and synchronous read, written by either the clear counter or the request path.

Verification (bench ADDR_W=4, DATA_W=16, INIT_CLEAR=1)
REQ-038 SHALL check reset then release: busy=1 for exactly 16 cycles, then req_ready=1; reads of addresses 0..15 all return 16'h0000.
REQ-039 SHALL check write addr 3 = 16'hBEEF, then read addr 3 in the next cycle: resp_valid=1 exactly one cycle after acceptance, with resp_rdata=16'hBEEF.
REQ-040 SHALL check back-to-back reads of addr 1,2,3 (holding 16'h0011, 16'h0022, 16'h0033) with resp_ready=1: resp_valid is continuous for 3 cycles with rdata 0011, 0022, 0033 in order.
REQ-041 SHALL check a read with resp_ready=0 for 4 cycles: resp_rdata stays stable, req_ready=0 during the hold, and after resp_ready=1 the response is consumed once.
REQ-042 SHALL check a request with req_rd=1 and req_we=1 at addr 5 with wdata 16'h1234: err pulses for one cycle, no response, and a later read of addr 5 returns its prior value.
REQ-043 SHALL check rst asserted at clear count 7: busy stays 1, the sweep restarts at 0, and busy stays high for 16 cycles after release.
